l0_assoc_cache: RTL and testbench
=================================

L0_ASSOC_CACHE -- requirements
Module: l0_assoc_cache

Interface
REQ-001 Parameter NUM_WAYS, default 2: associativity; power of two, 1 to 8.
REQ-002 Parameter NUM_SETS, default 64: sets per way; power of two, at least 2.
REQ-003 Parameter XLEN, default 32: data word width; fixed at 32.
REQ-004 Parameter MEM_BYTE_ADDR_WIDTH, default 16: cacheable byte-address width.
REQ-005 Parameter MMIO_ADDR, default 32'h4000_0000: addresses at or above this bypass the cache.
REQ-006 Port i_clk, input, 1: single clock, all state on rising edge.
REQ-007 Port i_rst, input, 1: reset, asynchronous, active-high.
REQ-008 Port i_stall, input, 1: holds the registered lookup outputs.
REQ-009 Port i_lookup_valid, input, 1: a load lookup is presented this cycle.
REQ-010 Port i_lookup_addr, input, 32: load byte address.
REQ-011 Port i_lookup_size, input, 2: access size; 0 byte, 1 halfword, 2 word.
REQ-012 Port o_hit, output, 1: combinational hit for the current lookup.
REQ-013 Port o_rdata, output, 32: raw word from the hit way; 0 on miss.
REQ-014 Port o_hit_q / o_rdata_q, output, 1 / 32: registered copies of o_hit / o_rdata.
REQ-015 Port i_store_valid / i_store_addr / i_store_data / i_store_be, input, 1 / 32 / 32 / 4: write-through store or AMO result.
REQ-016 Port i_fill_valid / i_fill_addr / i_fill_data, input, 1 / 32 / 32: full word returned from memory after a load miss.
REQ-017 Port i_inval_all, input, 1: single-cycle pulse requesting a full invalidate.
REQ-018 Port o_busy, output, 1: reset or invalidate sweep in progress.
REQ-019 Port o_hit_count / o_miss_count, output, 32 / 32: saturating lookup statistics.

Function
REQ-020 Address split: index = addr[2 +: log2(NUM_SETS)]; tag = addr[MEM_BYTE_ADDR_WIDTH-1 : 2+log2(NUM_SETS)]; offset = addr[1:0].
REQ-021 An address is non-cacheable if it is at or above MMIO_ADDR, or if any bit of addr[31:MEM_BYTE_ADDR_WIDTH] is 1.
REQ-022 Each way/set entry holds 4 data bytes, one tag and 4 per-byte valid bits.
REQ-023 Each set holds a round-robin victim pointer of log2(NUM_WAYS) bits, or none when NUM_WAYS=1.
REQ-024 o_hit is 1 iff all of these hold: i_lookup_valid, cacheable address, o_busy=0, and some way has a matching tag with every accessed byte valid.
REQ-025 Accessed bytes by size: byte uses [offset]; halfword uses [offset+1:offset]; word uses all four bytes.
REQ-026 A halfword at offset 3, or a word at offset not 0, is a miss.
REQ-027 A lookup to the same set as a same-cycle write returns pre-write contents; the write is visible the next cycle.
REQ-028 Tag matches in more than one way cannot occur by construction; the lowest matching way wins.
REQ-029 o_hit_q and o_rdata_q load o_hit and o_rdata on each edge where i_stall=0, and hold otherwise.
REQ-030 Write priority is store over fill; at most one array write per cycle; a fill presented with a store is dropped.
REQ-031 No write occurs while o_busy=1, or when the target address is non-cacheable.
REQ-032 Store, tag hit in way w: write enabled bytes of way w; valid = old valid | i_store_be; pointer unchanged.
REQ-033 Store, tag miss: write victim way = pointer; tag replaced; valid = i_store_be; pointer advances by 1 modulo NUM_WAYS.
REQ-034 Fill, tag hit in way w: write all 4 bytes of way w with valid=4'b1111; pointer unchanged.
REQ-035 Fill, tag miss: allocate the victim way as in REQ-033 with valid=4'b1111.
REQ-036 FSM has two states, SWEEP and IDLE; o_busy=1 exactly in SWEEP.
REQ-037 SWEEP clears valid bits and the pointer for set sweep_idx in all ways each cycle, then increments sweep_idx.
REQ-038 SWEEP goes to IDLE after clearing set NUM_SETS-1, so the sweep lasts exactly NUM_SETS cycles.
REQ-039 i_inval_all in IDLE: enter SWEEP with sweep_idx=0 on the next edge.
REQ-040 i_inval_all during SWEEP: sweep_idx restarts at 0.
REQ-041 Per lookup with i_lookup_valid=1 and o_busy=0: hit increments o_hit_count, miss increments o_miss_count.
REQ-042 Non-cacheable lookups are not counted; both counters saturate at 32'hFFFF_FFFF.

Reset
REQ-043 i_rst asserted: FSM=SWEEP, sweep_idx=0, o_hit_q=0, o_rdata_q=0, both counters 0, all pointers 0, immediately and independent of clock.
REQ-044 After i_rst deasserts, o_busy stays 1 for exactly NUM_SETS rising edges.
REQ-045 Reset asserted mid-sweep or mid-traffic restarts the sweep at index 0; any in-flight write is discarded.
REQ-046 Data and tag arrays are not reset.

Verification
REQ-047 Reset with NUM_SETS=16 -> o_busy=1 for exactly 16 cycles; word lookup of 0x0000_0100 gives o_hit=0; counters stay 0 during the sweep.
REQ-048 Fill 0x0000_0100 with data 0xDEAD_BEEF, then word lookup of the same address next cycle -> o_hit=1, o_rdata=0xDEAD_BEEF; o_hit_q=1 one edge later.
REQ-049 NUM_WAYS=2, NUM_SETS=16: fill 0x000, 0x040, 0x080 -> 0x000 evicted; 0x040 and 0x080 hit; 0x000 misses; o_miss_count=1.
REQ-050 Store to 0x0000_0204 with be=4'b0010 and data 0x0000_AB00 on a miss -> byte lookup at 0x205 hits with o_rdata[15:8]=0xAB; word lookup at 0x204 misses; same-cycle fill to 0x204 is dropped.
REQ-051 Store to 0x4000_0000 or to 0x0001_0000 -> no array change; a later lookup misses and is not counted for the MMIO address.
REQ-052 Hit on 0x100, pulse i_inval_all, pulse it again 5 cycles later -> o_busy=1 for 5+16 cycles; 0x100 misses afterwards; stores during the sweep are ignored.

Source files
------------

// File: rtl/l0_assoc_cache.sv
// Small set-associative L0 load cache with per-byte valid bits, write-through store update,
// fill allocation with round-robin victims, and a set-by-set invalidate sweep after reset or flush.
module l0_assoc_cache #(
  parameter int          NUM_WAYS            = 2,
  parameter int          NUM_SETS            = 64,
  parameter int          XLEN                = 32,
  parameter int          MEM_BYTE_ADDR_WIDTH = 16,
  parameter logic [31:0] MMIO_ADDR           = 32'h4000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  input  logic            i_lookup_valid,
  input  logic [31:0]     i_lookup_addr,
  input  logic [1:0]      i_lookup_size,
  output logic            o_hit,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_hit_q,
  output logic [XLEN-1:0] o_rdata_q,
  input  logic            i_store_valid,
  input  logic [31:0]     i_store_addr,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [3:0]      i_store_be,
  input  logic            i_fill_valid,
  input  logic [31:0]     i_fill_addr,
  input  logic [XLEN-1:0] i_fill_data,
  input  logic            i_inval_all,
  output logic            o_busy,
  output logic [31:0]     o_hit_count,
  output logic [31:0]     o_miss_count
);
  localparam int IDXW = $clog2(NUM_SETS);
  localparam int TAGW = MEM_BYTE_ADDR_WIDTH - 2 - IDXW;
  localparam int PTRW = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic {SWEEP, IDLE} state_t;

  function automatic logic cacheable(input logic [31:0] a);
    return (a < MMIO_ADDR) && ((a >> MEM_BYTE_ADDR_WIDTH) == 32'd0);
  endfunction

  logic [XLEN-1:0] r_data  [NUM_WAYS][NUM_SETS];
  logic [TAGW-1:0] r_tag   [NUM_WAYS][NUM_SETS];
  logic [3:0]      r_valid [NUM_WAYS][NUM_SETS];
  logic [PTRW-1:0] r_ptr   [NUM_SETS];

  state_t          r_state;
  logic [IDXW-1:0] r_sweep_idx;
  logic [31:0]     r_hit_cnt, r_miss_cnt;

  assign o_busy       = (r_state == SWEEP);
  assign o_hit_count  = r_hit_cnt;
  assign o_miss_count = r_miss_cnt;

  // ---------------- lookup ----------------
  logic [IDXW-1:0] w_lk_idx;
  logic [TAGW-1:0] w_lk_tag;
  logic [1:0]      w_lk_off;
  logic [3:0]      w_lk_mask;
  logic            w_lk_any, w_lk_en;
  logic [XLEN-1:0] w_lk_word;

  assign w_lk_idx = i_lookup_addr[2 +: IDXW];
  assign w_lk_tag = i_lookup_addr[MEM_BYTE_ADDR_WIDTH-1 -: TAGW];
  assign w_lk_off = i_lookup_addr[1:0];

  // A zero mask marks a misaligned or unsupported access, which can never hit.
  always_comb begin
    w_lk_mask = 4'b0000;
    case (i_lookup_size)
      2'd0:    w_lk_mask = 4'b0001 << w_lk_off;
      2'd1:    if (w_lk_off != 2'd3) w_lk_mask = 4'b0011 << w_lk_off;
      2'd2:    if (w_lk_off == 2'd0) w_lk_mask = 4'b1111;
      default: w_lk_mask = 4'b0000;
    endcase
  end

  always_comb begin
    w_lk_any  = 1'b0;
    w_lk_word = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (r_tag[w][w_lk_idx] == w_lk_tag &&
          (r_valid[w][w_lk_idx] & w_lk_mask) == w_lk_mask) begin
        w_lk_any  = 1'b1;
        w_lk_word = r_data[w][w_lk_idx];
      end
    end
  end

  assign w_lk_en = i_lookup_valid && cacheable(i_lookup_addr) && !o_busy;
  assign o_hit   = w_lk_en && (w_lk_mask != 4'b0000) && w_lk_any;
  assign o_rdata = o_hit ? w_lk_word : '0;

  // ---------------- array write (store beats fill) ----------------
  logic [31:0]     w_wr_addr;
  logic [IDXW-1:0] w_wr_idx;
  logic [TAGW-1:0] w_wr_tag;
  logic            w_wr_en, w_wr_hit;
  logic [PTRW-1:0] w_wr_hway, w_wr_way;
  logic [3:0]      w_wr_be, w_wr_valid;
  logic [XLEN-1:0] w_wr_data;
  logic            w_unused;

  assign w_wr_addr = i_store_valid ? i_store_addr : i_fill_addr;
  assign w_wr_idx  = w_wr_addr[2 +: IDXW];
  assign w_wr_tag  = w_wr_addr[MEM_BYTE_ADDR_WIDTH-1 -: TAGW];
  assign w_wr_en   = (i_store_valid || i_fill_valid) && cacheable(w_wr_addr) && !o_busy;
  assign w_unused  = ^w_wr_addr[1:0];

  always_comb begin
    w_wr_hit  = 1'b0;
    w_wr_hway = '0;
    for (int w = NUM_WAYS-1; w >= 0; w--) begin
      if (r_valid[w][w_wr_idx] != 4'b0000 && r_tag[w][w_wr_idx] == w_wr_tag) begin
        w_wr_hit  = 1'b1;
        w_wr_hway = PTRW'(w);
      end
    end
  end

  assign w_wr_way   = w_wr_hit ? w_wr_hway : r_ptr[w_wr_idx];
  assign w_wr_be    = i_store_valid ? i_store_be : 4'b1111;
  assign w_wr_data  = i_store_valid ? i_store_data : i_fill_data;
  assign w_wr_valid = !i_store_valid ? 4'b1111 :
                      (w_wr_hit ? (r_valid[w_wr_hway][w_wr_idx] | i_store_be) : i_store_be);

  // Arrays carry no reset; the sweep is what makes valid bits trustworthy.
  always_ff @(posedge i_clk) begin
    if (r_state == SWEEP) begin
      for (int w = 0; w < NUM_WAYS; w++) r_valid[w][r_sweep_idx] <= 4'b0000;
    end else if (w_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (w_wr_be[b]) r_data[w_wr_way][w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      r_tag[w_wr_way][w_wr_idx]   <= w_wr_tag;
      r_valid[w_wr_way][w_wr_idx] <= w_wr_valid;
    end
  end

  // ---------------- control, pointers, outputs, statistics ----------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= SWEEP;
      r_sweep_idx <= '0;
      o_hit_q     <= 1'b0;
      o_rdata_q   <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      for (int s = 0; s < NUM_SETS; s++) r_ptr[s] <= '0;
    end else begin
      if (!i_stall) begin
        o_hit_q   <= o_hit;
        o_rdata_q <= o_rdata;
      end
      if (w_lk_en) begin
        if (o_hit) begin
          if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
        end else begin
          if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
      end
      case (r_state)
        SWEEP: begin
          r_ptr[r_sweep_idx] <= '0;
          if (i_inval_all) r_sweep_idx <= '0;
          else begin
            r_sweep_idx <= r_sweep_idx + IDXW'(1);
            if (r_sweep_idx == IDXW'(NUM_SETS-1)) r_state <= IDLE;
          end
        end
        default: begin
          if (i_inval_all) begin
            r_state     <= SWEEP;
            r_sweep_idx <= '0;
          end
          if (w_wr_en && !w_wr_hit && NUM_WAYS > 1)
            r_ptr[w_wr_idx] <= r_ptr[w_wr_idx] + PTRW'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_l0_assoc_cache.sv
// Directed bench for l0_assoc_cache (2 ways x 16 sets): sweep timing, fills, eviction,
// partial stores, alignment misses, MMIO bypass, flush restart and async reset.
module tb_l0_assoc_cache;
  logic        clk, rst, stall;
  logic        lk_valid;
  logic [31:0] lk_addr;
  logic [1:0]  lk_size;
  logic        hit, hit_q, busy;
  logic [31:0] rdata, rdata_q, hit_cnt, miss_cnt;
  logic        st_valid;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_be;
  logic        fl_valid;
  logic [31:0] fl_addr, fl_data;
  logic        inval;

  int n_cmp = 0;
  int n_err = 0;

  l0_assoc_cache #(.NUM_WAYS(2), .NUM_SETS(16), .XLEN(32), .MEM_BYTE_ADDR_WIDTH(16),
                   .MMIO_ADDR(32'h4000_0000)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .i_lookup_valid(lk_valid), .i_lookup_addr(lk_addr), .i_lookup_size(lk_size),
    .o_hit(hit), .o_rdata(rdata), .o_hit_q(hit_q), .o_rdata_q(rdata_q),
    .i_store_valid(st_valid), .i_store_addr(st_addr), .i_store_data(st_data), .i_store_be(st_be),
    .i_fill_valid(fl_valid), .i_fill_addr(fl_addr), .i_fill_data(fl_data),
    .i_inval_all(inval), .o_busy(busy), .o_hit_count(hit_cnt), .o_miss_count(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then drop every single-cycle request.
  task automatic tick();
    @(posedge clk);
    #1;
    lk_valid = 1'b0; st_valid = 1'b0; fl_valid = 1'b0; inval = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a, input logic [31:0] d);
    fl_valid = 1'b1; fl_addr = a; fl_data = d;
    tick();
  endtask

  task automatic present(input logic [31:0] a, input logic [1:0] sz);
    lk_valid = 1'b1; lk_addr = a; lk_size = sz;
    #1;
  endtask

  task automatic look(input logic [31:0] a, input logic [1:0] sz, input logic eh,
                      input logic [31:0] ed, input string tag);
    present(a, sz);
    chk({tag, "_hit"}, {31'd0, hit}, {31'd0, eh});
    chk({tag, "_data"}, rdata, eh ? ed : 32'd0);
    tick();
  endtask

  initial begin
    int n;
    rst = 1'b0; stall = 1'b0; inval = 1'b0;
    lk_valid = 1'b0; lk_addr = '0; lk_size = '0;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    fl_valid = 1'b0; fl_addr = '0; fl_data = '0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_hit_q", {31'd0, hit_q}, 32'd0);
    chk("rst_rdata_q", rdata_q, 32'd0);
    chk("rst_hit_cnt", hit_cnt, 32'd0);
    chk("rst_miss_cnt", miss_cnt, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Sweep after reset: lookups miss and are not counted.
    present(32'h0000_0100, 2'd2);
    chk("sweep_lookup_hit", {31'd0, hit}, 32'd0);
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    chk("reset_sweep_len", n, 32'd16);
    chk("sweep_hit_cnt", hit_cnt, 32'd0);
    chk("sweep_miss_cnt", miss_cnt, 32'd0);

    // Round-robin eviction in set 0.
    fill(32'h0000_0000, 32'hA0A0_0000);
    fill(32'h0000_0040, 32'hA1A1_1111);
    fill(32'h0000_0080, 32'hA2A2_2222);
    look(32'h0000_0040, 2'd2, 1'b1, 32'hA1A1_1111, "rr_040");
    look(32'h0000_0080, 2'd2, 1'b1, 32'hA2A2_2222, "rr_080");
    look(32'h0000_0000, 2'd2, 1'b0, 32'd0, "rr_000");
    chk("rr_hit_cnt", hit_cnt, 32'd2);
    chk("rr_miss_cnt", miss_cnt, 32'd1);

    // Fill then hit; registered copy one edge later.
    fill(32'h0000_0100, 32'hDEAD_BEEF);
    chk("hit_q_before", {31'd0, hit_q}, 32'd0);
    look(32'h0000_0100, 2'd2, 1'b1, 32'hDEAD_BEEF, "fill_100");
    chk("hit_q_after", {31'd0, hit_q}, 32'd1);
    chk("rdata_q_after", rdata_q, 32'hDEAD_BEEF);

    // Stall holds the registered outputs across a miss.
    stall = 1'b1;
    look(32'h0000_0140, 2'd2, 1'b0, 32'd0, "stall_140");
    chk("stall_hit_q", {31'd0, hit_q}, 32'd1);
    chk("stall_rdata_q", rdata_q, 32'hDEAD_BEEF);
    stall = 1'b0;

    // Size / offset handling.
    look(32'h0000_0102, 2'd0, 1'b1, 32'hDEAD_BEEF, "byte_102");
    look(32'h0000_0103, 2'd1, 1'b0, 32'd0, "half_off3");
    chk("hit_q_miss", {31'd0, hit_q}, 32'd0);
    look(32'h0000_0101, 2'd2, 1'b0, 32'd0, "word_off1");
    look(32'h0000_0102, 2'd1, 1'b1, 32'hDEAD_BEEF, "half_102");

    // Same-cycle store: lookup sees the old word, next cycle the new one.
    st_valid = 1'b1; st_addr = 32'h0000_0100; st_data = 32'h1234_5678; st_be = 4'b1111;
    look(32'h0000_0100, 2'd2, 1'b1, 32'hDEAD_BEEF, "wr_same_cyc");
    look(32'h0000_0100, 2'd2, 1'b1, 32'h1234_5678, "wr_next_cyc");

    // Partial store on a miss; simultaneous fill is dropped.
    st_valid = 1'b1; st_addr = 32'h0000_0204; st_data = 32'h0000_AB00; st_be = 4'b0010;
    fl_valid = 1'b1; fl_addr = 32'h0000_0204; fl_data = 32'hFFFF_FFFF;
    tick();
    present(32'h0000_0205, 2'd0);
    chk("pstore_byte_hit", {31'd0, hit}, 32'd1);
    chk("pstore_byte_val", {24'd0, rdata[15:8]}, 32'h0000_00AB);
    tick();
    look(32'h0000_0204, 2'd2, 1'b0, 32'd0, "pstore_word");

    // Non-cacheable stores change nothing; 0x1_0000 would alias tag 0 of set 0.
    st_valid = 1'b1; st_addr = 32'h4000_0000; st_data = 32'h5A5A_5A5A; st_be = 4'b1111;
    tick();
    st_valid = 1'b1; st_addr = 32'h0001_0000; st_data = 32'h6B6B_6B6B; st_be = 4'b1111;
    tick();
    look(32'h0000_0000, 2'd2, 1'b0, 32'd0, "nc_alias_000");
    look(32'h0000_0080, 2'd2, 1'b1, 32'hA2A2_2222, "nc_keep_080");
    look(32'h4000_0000, 2'd2, 1'b0, 32'd0, "mmio_look");
    look(32'h0001_0000, 2'd2, 1'b0, 32'd0, "hi_look");
    chk("nc_hit_cnt", hit_cnt, 32'd9);
    chk("nc_miss_cnt", miss_cnt, 32'd6);

    // Flush, restarted 5 cycles later, with a store during the sweep.
    look(32'h0000_0100, 2'd2, 1'b1, 32'h1234_5678, "pre_inval");
    inval = 1'b1;
    tick();
    chk("inval_busy", {31'd0, busy}, 32'd1);
    present(32'h0000_0100, 2'd2);
    chk("inval_lookup_hit", {31'd0, hit}, 32'd0);
    tick();
    repeat (3) tick();
    inval = 1'b1;
    st_valid = 1'b1; st_addr = 32'h0000_0300; st_data = 32'h5555_5555; st_be = 4'b1111;
    tick();
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    chk("restart_sweep_len", n, 32'd16);
    look(32'h0000_0100, 2'd2, 1'b0, 32'd0, "post_inval_100");
    look(32'h0000_0300, 2'd2, 1'b0, 32'd0, "sweep_store_300");
    chk("final_hit_cnt", hit_cnt, 32'd10);
    chk("final_miss_cnt", miss_cnt, 32'd8);

    // Asynchronous reset between edges.
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_hit_cnt", hit_cnt, 32'd0);
    chk("async_miss_cnt", miss_cnt, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
